pop_button_conditioner: RTL and testbench
=========================================

# pop_button_conditioner

Conditions the five front-panel pushbuttons into clean single-cycle pulses on the 2.5 MHz clock domain, directly upstream of the POP timer's adjustable π/2 and free-precession counters. Each button is synchronised, debounced, edge-detected and, for the four adjust buttons, auto-repeated while held. Conflicting presses are arbitrated. Optionally, adjust pulses are deferred to the POP cycle boundary so a sequence is never altered mid-cycle.

## Interface
- DEBOUNCE_CYCLES, 25000: consecutive stable cycles needed to accept a level change (10 ms).
- REPEAT_DELAY, 1250000: hold time after the first pulse before auto-repeat starts (500 ms).
- REPEAT_PERIOD, 250000: spacing between auto-repeat pulses (100 ms).
- CNT_WIDTH, 21: timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- clk_2M5  input  1  2.5 MHz system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_n  input  5  raw buttons, active-low, asynchronous; [0] π/2+, [1] π/2−, [2] free-precession+, [3] free-precession−, [4] load defaults.
- cycle_sync  input  1  one-cycle pulse at the start of each POP cycle (used only with the macro).
- pieovertwo_plus  output  1  one-cycle increment pulse.
- pieovertwo_minus  output  1  one-cycle decrement pulse.
- freeprecess_plus  output  1  one-cycle increment pulse.
- freeprecess_minus  output  1  one-cycle decrement pulse.
- load_defaults  output  1  one-cycle restore-defaults pulse.
- pending  output  1  high while any deferred adjust pulse awaits cycle_sync (always 0 without the macro).

## Operation
- Each btn_n bit passes through a 2-flop synchroniser, then is inverted to give a pressed level.
- Each channel has its own FSM with states IDLE, PRESS_DB, HELD, REPEAT and RELEASE_DB.
  - IDLE → PRESS_DB when pressed is seen.
  - PRESS_DB: the timer counts while pressed. Any unpressed sample returns the channel to IDLE. After DEBOUNCE_CYCLES consecutive pressed samples the channel emits one raw pulse and goes to HELD.
  - HELD: the timer counts to REPEAT_DELAY, then the channel emits a raw pulse and goes to REPEAT. An unpressed sample goes to RELEASE_DB.
  - REPEAT: the channel emits a raw pulse every REPEAT_PERIOD cycles. An unpressed sample goes to RELEASE_DB.
  - RELEASE_DB: after DEBOUNCE_CYCLES consecutive unpressed samples the channel goes to IDLE. Any pressed sample restarts the count and does not re-emit a pulse.
- Channel 4 (load defaults) has no auto-repeat. HELD simply waits for release.
- Arbitration is applied to raw pulses in the same cycle:
  - If + and − of the same pair pulse together, both are dropped.
  - A load-defaults raw pulse drops every adjust pulse in that cycle.
- Timers saturate and never wrap. Each timer clears on every state change.

## Timing
- All outputs and pending reset to 0. All FSMs reset to IDLE and all timers to 0. The synchroniser flops reset to 1 (released).
- Assertion of reset_n mid-press returns the channel to IDLE. A button still held after release of reset_n must be debounced afresh and then produces exactly one pulse.
- Outputs are registered and high for exactly one clk_2M5 cycle.
- Latency: edge E0 is the first rising edge that samples the new btn_n level. Given a clean level change, the output pulse is high in the cycle following edge E0+2+DEBOUNCE_CYCLES.
- Auto-repeat: the first repeat pulse follows the initial pulse by REPEAT_DELAY cycles. Subsequent repeat pulses occur every REPEAT_PERIOD cycles.
- load_defaults is never deferred, in either configuration.

## Configuration
- Macro: POP_BTN_CYCLE_ALIGN_EN.
- Defined:
  - Each adjust output has a pending bit, set by an arbitrated raw pulse.
  - On cycle_sync all set pending bits are emitted in that cycle and cleared.
  - Multiple raw pulses before cycle_sync collapse to one.
  - If both + and − of a pair are pending at cycle_sync, both are cleared with no output.
  - A raw pulse coincident with cycle_sync is emitted immediately.
  - load_defaults clears all pending bits.
  - pending = OR of the pending bits.
- Undefined: arbitrated raw pulses drive the outputs directly, cycle_sync is ignored, and pending is tied to 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Bounce then hold: btn_n[0] toggles 0/1 every 2 cycles for 10 cycles, then is held at 0 for 15 cycles → exactly one pieovertwo_plus pulse, occurring 7 cycles after the final falling edge is sampled. No other outputs.
- Auto-repeat: btn_n[2] held low for 60 cycles → freeprecess_plus pulses at relative cycles 0, 20, 28, 36, 44, 52 (6 pulses). After release, none follow.
- Conflict: btn_n[0] and btn_n[1] fall in the same cycle and are held for 10 cycles → no pulse on either output. With btn_n[4] also falling in that cycle → a single load_defaults pulse and no adjust pulse.
- Reset mid-operation: btn_n[3] held, reset_n pulsed low during HELD, button still held → all outputs are 0 during reset. One freeprecess_minus pulse follows DEBOUNCE_CYCLES+2 cycles after reset release.
- Macro defined: three btn_n[0] presses completed with cycle_sync held low, then a cycle_sync pulse → pending stays high until cycle_sync. Exactly one pieovertwo_plus pulse occurs in the cycle_sync cycle, then pending drops to 0.
- Macro defined: pending π/2+ followed by a load-defaults press → load_defaults pulses and pending clears. The next cycle_sync produces no pulse.

Source files
------------

// File: rtl/pop_button_conditioner.sv
// Front-panel button conditioner for the POP timer: sync, debounce, auto-repeat, arbitration.
// Define POP_BTN_CYCLE_ALIGN_EN to defer adjust pulses to the next cycle_sync.

module pop_btn_channel #(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int REPEAT_DELAY    = 1250000,
    parameter int REPEAT_PERIOD   = 250000,
    parameter int CNT_WIDTH       = 21,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk_2M5,
    input  logic reset_n,
    input  logic i_pressed,
    output logic o_raw_pulse
);

    // state      | meaning
    // IDLE       | debounced released, waiting for a press
    // PRESS_DB   | press seen, counting consecutive pressed samples
    // HELD       | press accepted, waiting for repeat delay or release
    // REPEAT     | auto-repeating every REPEAT_PERIOD cycles
    // RELEASE_DB | release seen, counting consecutive released samples
    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DB_LAST         = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_timer;
    logic [CNT_WIDTH-1:0] w_timer_nxt;
    logic [CNT_WIDTH-1:0] w_timer_sat;

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Saturating increment: a long hold on the no-repeat channel parks at all-ones.
    assign w_timer_sat = (r_timer == '1) ? r_timer : r_timer + CNT_WIDTH'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_timer_sat;
        o_raw_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (i_pressed) begin
                    w_state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!i_pressed) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer >= DB_LAST) begin
                    o_raw_pulse = 1'b1;
                    w_state_nxt = HELD;
                    w_timer_nxt = '0;
                end
            end
            HELD: begin
                if (!i_pressed) begin
                    w_state_nxt = RELEASE_DB;
                    w_timer_nxt = '0;
                end else if (REPEAT_EN && (r_timer >= RPT_DELAY_LAST)) begin
                    o_raw_pulse = 1'b1;
                    w_state_nxt = REPEAT;
                    w_timer_nxt = '0;
                end
            end
            REPEAT: begin
                if (!i_pressed) begin
                    w_state_nxt = RELEASE_DB;
                    w_timer_nxt = '0;
                end else if (r_timer >= RPT_PERIOD_LAST) begin
                    o_raw_pulse = 1'b1;
                    w_timer_nxt = '0;
                end
            end
            RELEASE_DB: begin
                if (i_pressed) begin
                    w_timer_nxt = '0;
                end else if (r_timer >= DB_LAST) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

endmodule

module pop_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int REPEAT_DELAY    = 1250000,
    parameter int REPEAT_PERIOD   = 250000,
    parameter int CNT_WIDTH       = 21
) (
    input  logic       clk_2M5,
    input  logic       reset_n,
    input  logic [4:0] btn_n,
    input  logic       cycle_sync,
    output logic       pieovertwo_plus,
    output logic       pieovertwo_minus,
    output logic       freeprecess_plus,
    output logic       freeprecess_minus,
    output logic       load_defaults,
    output logic       pending
);

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_pressed;
    logic [4:0] w_raw;
    logic [4:0] w_arb;
    logic [3:0] w_adj;
    logic [4:0] r_out;

    // Synchroniser idles at 1 so a reset never looks like a press.
    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    for (genvar g = 0; g < 5; g++) begin : g_chan
        pop_btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .CNT_WIDTH      (CNT_WIDTH),
            .REPEAT_EN      (g != 4)
        ) u_chan (
            .clk_2M5    (clk_2M5),
            .reset_n    (reset_n),
            .i_pressed  (w_pressed[g]),
            .o_raw_pulse(w_raw[g])
        );
    end

    // Opposing presses of a pair cancel; load-defaults overrides every adjust.
    assign w_arb[0] = w_raw[0] & ~w_raw[1] & ~w_raw[4];
    assign w_arb[1] = w_raw[1] & ~w_raw[0] & ~w_raw[4];
    assign w_arb[2] = w_raw[2] & ~w_raw[3] & ~w_raw[4];
    assign w_arb[3] = w_raw[3] & ~w_raw[2] & ~w_raw[4];
    assign w_arb[4] = w_raw[4];

`ifdef POP_BTN_CYCLE_ALIGN_EN
    logic [3:0] r_pend;
    logic [3:0] w_pend_nxt;
    logic [3:0] w_cand;

    always_comb begin
        w_cand     = r_pend | w_arb[3:0];
        w_pend_nxt = w_cand;
        w_adj      = '0;
        if (w_arb[4]) begin
            w_pend_nxt = '0;
        end else if (cycle_sync) begin
            w_pend_nxt = '0;
            w_adj[0]   = w_cand[0] & ~w_cand[1];
            w_adj[1]   = w_cand[1] & ~w_cand[0];
            w_adj[2]   = w_cand[2] & ~w_cand[3];
            w_adj[3]   = w_cand[3] & ~w_cand[2];
        end
    end

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pending = |r_pend;
`else
    logic w_unused_sync;

    assign w_unused_sync = cycle_sync;
    assign w_adj         = w_arb[3:0];
    assign pending       = 1'b0;
`endif

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= {w_arb[4], w_adj};
        end
    end

    assign pieovertwo_plus   = r_out[0];
    assign pieovertwo_minus  = r_out[1];
    assign freeprecess_plus  = r_out[2];
    assign freeprecess_minus = r_out[3];
    assign load_defaults     = r_out[4];

endmodule

// File: tb/tb_pop_button_conditioner.sv
// Scoreboard bench for pop_button_conditioner: run-length reference model plus directed scenarios.
// Honours POP_BTN_CYCLE_ALIGN_EN when the DUT is built with it.

module tb_pop_button_conditioner;

    localparam int D = 4;
    localparam int R = 20;
    localparam int P = 8;

    logic       clk_2M5;
    logic       reset_n;
    logic [4:0] btn_n;
    logic       cycle_sync;
    logic       pieovertwo_plus;
    logic       pieovertwo_minus;
    logic       freeprecess_plus;
    logic       freeprecess_minus;
    logic       load_defaults;
    logic       pending;

    pop_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (R),
        .REPEAT_PERIOD  (P),
        .CNT_WIDTH      (21)
    ) dut (
        .clk_2M5          (clk_2M5),
        .reset_n          (reset_n),
        .btn_n            (btn_n),
        .cycle_sync       (cycle_sync),
        .pieovertwo_plus  (pieovertwo_plus),
        .pieovertwo_minus (pieovertwo_minus),
        .freeprecess_plus (freeprecess_plus),
        .freeprecess_minus(freeprecess_minus),
        .load_defaults    (load_defaults),
        .pending          (pending)
    );

    initial clk_2M5 = 1'b0;
    always #5 clk_2M5 = ~clk_2M5;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;
    int   pulse_cnt[5] = '{0, 0, 0, 0, 0};
    int   base_cnt[5]  = '{0, 0, 0, 0, 0};

    // Reference model: per button, phase 0 = released, 1 = accepted/held, 2 = releasing.
    int         phase[5];
    int         press_run[5];
    int         rel_run[5];
    int         hold_h[5];
    logic [4:0] m_hist[$];
    logic [4:0] m_prs;
    logic [4:0] m_raw;
    logic [4:0] m_vec;
    logic [3:0] m_adj;
    logic [3:0] m_pend;
    exp_t       m_e;

    always @(posedge clk_2M5) begin
        edge_n++;
        m_vec = '0;
        if (!reset_n) begin
            for (int ch = 0; ch < 5; ch++) begin
                phase[ch] = 0; press_run[ch] = 0; rel_run[ch] = 0; hold_h[ch] = 0;
            end
            m_hist = '{5'h1F, 5'h1F};
            m_pend = '0;
        end else begin
            // The debouncer sees the level that was on the pins two edges ago.
            m_prs = ~m_hist.pop_front();
            m_hist.push_back(btn_n);
            for (int ch = 0; ch < 5; ch++) begin
                m_raw[ch] = 1'b0;
                case (phase[ch])
                    0: begin
                        if (m_prs[ch]) begin
                            press_run[ch]++;
                            if (press_run[ch] == D + 1) begin
                                m_raw[ch] = 1'b1; phase[ch] = 1; hold_h[ch] = 0;
                            end
                        end else begin
                            press_run[ch] = 0;
                        end
                    end
                    1: begin
                        if (!m_prs[ch]) begin
                            phase[ch] = 2; rel_run[ch] = 0;
                        end else begin
                            hold_h[ch]++;
                            if (ch != 4 && hold_h[ch] >= R && ((hold_h[ch] - R) % P) == 0)
                                m_raw[ch] = 1'b1;
                        end
                    end
                    default: begin
                        if (m_prs[ch]) begin
                            rel_run[ch] = 0;
                        end else begin
                            rel_run[ch]++;
                            if (rel_run[ch] == D) begin
                                phase[ch] = 0; press_run[ch] = 0;
                            end
                        end
                    end
                endcase
            end
            if (m_raw[4]) begin
                m_vec  = 5'b10000;
                m_pend = '0;
            end else begin
                m_adj = m_raw[3:0];
                for (int k = 0; k < 4; k += 2)
                    if (m_adj[k] && m_adj[k+1]) begin m_adj[k] = 1'b0; m_adj[k+1] = 1'b0; end
`ifdef POP_BTN_CYCLE_ALIGN_EN
                m_adj = m_adj | m_pend;
                if (cycle_sync) begin
                    for (int k = 0; k < 4; k += 2)
                        if (m_adj[k] && m_adj[k+1]) begin m_adj[k] = 1'b0; m_adj[k+1] = 1'b0; end
                    m_vec[3:0] = m_adj;
                    m_pend     = '0;
                end else begin
                    m_pend = m_adj;
                end
`else
                m_vec[3:0] = m_adj;
`endif
            end
        end
        m_e.cyc  = edge_n;
        m_e.vec  = m_vec;
        m_e.pend = |m_pend;
        sb.push_back(m_e);
    end

    // Monitor: compares whenever the DUT or the model shows a pulse, and pending every cycle.
    logic [4:0] mon_act;
    exp_t       mon_e;

    always begin
        @(posedge clk_2M5);
        #1;
        mon_act = {load_defaults, freeprecess_minus, freeprecess_plus, pieovertwo_minus, pieovertwo_plus};
        for (int i = 0; i < 5; i++) if (mon_act[i]) pulse_cnt[i]++;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_empty at edge %0d: no expectation queued", edge_n);
        end else begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (mon_e.cyc != edge_n) begin
                n_err++;
                $display("FAIL sb_order: entry for edge %0d, required edge %0d", mon_e.cyc, edge_n);
            end
            if (mon_act != 5'b0 || mon_e.vec != 5'b0 || !reset_n) begin
                n_cmp++;
                if (mon_act !== mon_e.vec) begin
                    n_err++;
                    $display("FAIL outputs at edge %0d: got %b, required %b", edge_n, mon_act, mon_e.vec);
                end
            end
            n_cmp++;
            if (pending !== mon_e.pend) begin
                n_err++;
                $display("FAIL pending at edge %0d: got %b, required %b", edge_n, pending, mon_e.pend);
            end
        end
    end

    task automatic hold(input logic [4:0] v, input int n);
        btn_n = v;
        repeat (n) @(negedge clk_2M5);
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) base_cnt[i] = pulse_cnt[i];
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_deltas(input string name, input int d0, input int d1, input int d2,
                              input int d3, input int d4);
        chk({name, "_p2p"}, pulse_cnt[0] - base_cnt[0], d0);
        chk({name, "_p2m"}, pulse_cnt[1] - base_cnt[1], d1);
        chk({name, "_fpp"}, pulse_cnt[2] - base_cnt[2], d2);
        chk({name, "_fpm"}, pulse_cnt[3] - base_cnt[3], d3);
        chk({name, "_ld"},  pulse_cnt[4] - base_cnt[4], d4);
    endtask

    logic [4:0] seg_m;
    int         seg_len;

    initial begin
        btn_n      = 5'h1F;
        cycle_sync = 1'b1;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk_2M5);
        chk("reset_outputs", {27'd0, load_defaults, freeprecess_minus, freeprecess_plus,
                              pieovertwo_minus, pieovertwo_plus}, 0);
        reset_n = 1'b1;
        hold(5'h1F, 4);

        snap();
        for (int i = 0; i < 5; i++) hold((i % 2) ? 5'h1F : 5'h1E, 2);
        hold(5'h1E, 15);
        hold(5'h1F, 12);
        chk_deltas("bounce", 1, 0, 0, 0, 0);

        snap();
        hold(5'h1B, 60);
        hold(5'h1F, 15);
        chk_deltas("repeat", 0, 0, 6, 0, 0);

        snap();
        hold(5'h1C, 10);
        hold(5'h1F, 12);
        chk_deltas("conflict", 0, 0, 0, 0, 0);

        snap();
        hold(5'h0C, 10);
        hold(5'h1F, 12);
        chk_deltas("conflict_ld", 0, 0, 0, 0, 1);

        hold(5'h17, 10);
        reset_n = 1'b0;
        hold(5'h17, 3);
        reset_n = 1'b1;
        snap();
        hold(5'h17, 15);
        hold(5'h1F, 12);
        chk_deltas("reset_hold", 0, 0, 0, 1, 0);

`ifdef POP_BTN_CYCLE_ALIGN_EN
        cycle_sync = 1'b0;
        snap();
        repeat (3) begin hold(5'h1E, 8); hold(5'h1F, 10); end
        chk("align_pending_set", int'(pending), 1);
        chk("align_no_early", pulse_cnt[0] - base_cnt[0], 0);
        cycle_sync = 1'b1;
        hold(5'h1F, 1);
        cycle_sync = 1'b0;
        hold(5'h1F, 3);
        chk_deltas("align_sync", 1, 0, 0, 0, 0);
        chk("align_pending_clr", int'(pending), 0);

        snap();
        hold(5'h1E, 8);
        hold(5'h1F, 10);
        chk("ld_pending_set", int'(pending), 1);
        hold(5'h0F, 8);
        hold(5'h1F, 10);
        chk("ld_pending_clr", int'(pending), 0);
        cycle_sync = 1'b1;
        hold(5'h1F, 1);
        cycle_sync = 1'b0;
        hold(5'h1F, 3);
        chk_deltas("ld_cancel", 0, 0, 0, 0, 1);
        cycle_sync = 1'b1;
`endif

        for (int s = 0; s < 160; s++) begin
            case ($urandom_range(0, 9))
                0:       seg_m = 5'(5'b1 << $urandom_range(0, 4)) | 5'(5'b1 << $urandom_range(0, 4));
                1:       seg_m = 5'($urandom_range(0, 31));
                default: seg_m = 5'(5'b1 << $urandom_range(0, 3));
            endcase
            seg_len = int'($urandom_range(1, 50));
            for (int i = 0; i < seg_len; i++) begin
                btn_n      = ~seg_m;
                if ($urandom_range(0, 9) == 0) btn_n = btn_n ^ 5'(5'b1 << $urandom_range(0, 4));
                cycle_sync = ($urandom_range(0, 11) == 0);
                @(negedge clk_2M5);
            end
            if ($urandom_range(0, 29) == 0) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk_2M5);
                reset_n = 1'b1;
            end
            btn_n   = 5'h1F;
            seg_len = int'($urandom_range(1, 14));
            for (int i = 0; i < seg_len; i++) begin
                cycle_sync = ($urandom_range(0, 11) == 0);
                @(negedge clk_2M5);
            end
        end

        btn_n      = 5'h1F;
        cycle_sync = 1'b1;
        repeat (12) @(negedge clk_2M5);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
